// File: rtl/ps2_scancode_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ps2_scancode_decoder: PS/2 Set-2 byte stream -> key events, show-ahead FIFO |
// | Optional typematic-repeat filter: define KEY_REPEAT_FILTER_EN               |
// | Revision: 1.0                                                               |
// +--------------------------------------------------------------------------+
module ps2_scancode_decoder #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic [7:0] received_data,
  input  logic       received_data_en,
  input  logic       evt_ready,
  output logic       evt_valid,
  output logic [7:0] evt_code,
  output logic       evt_extended,
  output logic       evt_released,
  output logic       evt_overflow
`ifdef KEY_REPEAT_FILTER_EN
  ,
  output logic [3:0] held_count
`endif
);

  localparam int         c_AW   = $clog2(FIFO_DEPTH);
  localparam int         c_TW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0] c_E0   = 8'hE0;
  localparam logic [7:0] c_E1   = 8'hE1;
  localparam logic [7:0] c_F0   = 8'hF0;
  localparam logic [7:0] c_FAKE = 8'h12;

  typedef enum logic [2:0] {S_IDLE, S_E0, S_F0, S_E0F0, S_PAUSE} state_t;

  state_t          state_q, state_d;
  logic [2:0]      skip_q, skip_d;
  logic [c_TW-1:0] tmo_q, tmo_d;
  logic            cand_d;
  logic [9:0]      cand_data_d;
  logic            push_d, push_q;
  logic [9:0]      push_data_q;
  logic            w_is_prefix, w_is_noise;

  always_comb begin
    w_is_prefix = (received_data == c_E0) || (received_data == c_E1) || (received_data == c_F0);
    w_is_noise  = received_data inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};
  end

  // Event candidate = {extended, released, code}; it is registered before entering the FIFO.
  always_comb begin
    state_d     = state_q;
    skip_d      = skip_q;
    tmo_d       = tmo_q;
    cand_d      = 1'b0;
    cand_data_d = {2'b00, received_data};
    if (received_data_en) begin
      tmo_d   = '0;
      state_d = S_IDLE;
      unique case (state_q)
        S_IDLE: begin
          if (received_data == c_E0) state_d = S_E0;
          else if (received_data == c_F0) state_d = S_F0;
          else if (received_data == c_E1) begin
            state_d = S_PAUSE;
            skip_d  = 3'd7;
          end else if (!w_is_noise) cand_d = 1'b1;
        end
        S_E0: begin
          if (received_data == c_F0) state_d = S_E0F0;
          else if (!w_is_prefix && received_data != c_FAKE) begin
            cand_d      = 1'b1;
            cand_data_d = {2'b10, received_data};
          end
        end
        S_F0: begin
          if (!w_is_prefix) begin
            cand_d      = 1'b1;
            cand_data_d = {2'b01, received_data};
          end
        end
        S_E0F0: begin
          if (!w_is_prefix && received_data != c_FAKE) begin
            cand_d      = 1'b1;
            cand_data_d = {2'b11, received_data};
          end
        end
        S_PAUSE: begin
          skip_d = skip_q - 1'b1;
          if (skip_q == 3'd1) begin
            cand_d      = 1'b1;
            cand_data_d = {2'b00, c_E1};
          end else state_d = S_PAUSE;
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE) begin
      if (tmo_q == c_TW'(TIMEOUT_CYCLES - 1)) begin
        state_d = S_IDLE;
        tmo_d   = '0;
      end else tmo_d = tmo_q + 1'b1;
    end
  end

`ifdef KEY_REPEAT_FILTER_EN
  logic [255:0] held_q, held_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [7:0]   w_key;

  // Bitmap index folds code[7] away; the Pause event is never tracked.
  always_comb begin
    held_d = held_q;
    cnt_d  = cnt_q;
    push_d = cand_d;
    w_key  = {cand_data_d[9], cand_data_d[6:0]};
    if (cand_d && cand_data_d[7:0] != c_E1) begin
      if (cand_data_d[8]) begin
        if (held_q[w_key]) begin
          held_d[w_key] = 1'b0;
          if (cnt_q != 4'd0) cnt_d = cnt_q - 1'b1;
        end
      end else if (held_q[w_key]) begin
        push_d = 1'b0;
      end else begin
        held_d[w_key] = 1'b1;
        if (cnt_q != 4'd15) cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      held_q <= '0;
      cnt_q  <= '0;
    end else begin
      held_q <= held_d;
      cnt_q  <= cnt_d;
    end
  end

  assign held_count = cnt_q;
`else
  assign push_d = cand_d;
`endif

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      skip_q      <= '0;
      tmo_q       <= '0;
      push_q      <= 1'b0;
      push_data_q <= '0;
    end else begin
      state_q     <= state_d;
      skip_q      <= skip_d;
      tmo_q       <= tmo_d;
      push_q      <= push_d;
      push_data_q <= cand_data_d;
    end
  end

  logic [9:0]    mem_q [FIFO_DEPTH];
  logic [c_AW:0] wr_q, rd_q;
  logic          ovf_q;
  logic          w_empty, w_full, w_pop, w_wr;
  logic [9:0]    w_head;

  always_comb begin
    w_empty = (wr_q == rd_q);
    w_full  = (wr_q[c_AW] != rd_q[c_AW]) && (wr_q[c_AW-1:0] == rd_q[c_AW-1:0]);
    w_pop   = !w_empty && evt_ready;
    w_wr    = push_q && (!w_full || w_pop);
    w_head  = w_empty ? 10'd0 : mem_q[rd_q[c_AW-1:0]];
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      wr_q  <= '0;
      rd_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (w_wr) wr_q <= wr_q + 1'b1;
      if (w_pop) rd_q <= rd_q + 1'b1;
      if (push_q && w_full && !w_pop) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (w_wr) mem_q[wr_q[c_AW-1:0]] <= push_data_q;
  end

  assign evt_valid                                 = !w_empty;
  assign {evt_extended, evt_released, evt_code}    = w_head;
  assign evt_overflow                              = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_scancode_decoder.sv
`default_nettype none
// Bench for ps2_scancode_decoder: randomized byte stream against a sequence-level
// reference model, with a scoreboard queue drained by an independent monitor.
module tb_ps2_scancode_decoder;
  localparam int TMO = 40;

  logic       clk = 1'b0;
  logic       resetn;
  logic [7:0] received_data;
  logic       received_data_en;
  logic       evt_ready;
  logic       evt_valid;
  logic [7:0] evt_code;
  logic       evt_extended;
  logic       evt_released;
  logic       evt_overflow;
`ifdef KEY_REPEAT_FILTER_EN
  logic [3:0] held_count;
`endif

  ps2_scancode_decoder #(.FIFO_DEPTH(8), .TIMEOUT_CYCLES(TMO)) dut (
    .CLOCK_50        (clk),
    .resetn          (resetn),
    .received_data   (received_data),
    .received_data_en(received_data_en),
    .evt_ready       (evt_ready),
    .evt_valid       (evt_valid),
    .evt_code        (evt_code),
    .evt_extended    (evt_extended),
    .evt_released    (evt_released),
    .evt_overflow    (evt_overflow)
`ifdef KEY_REPEAT_FILTER_EN
    ,
    .held_count      (held_count)
`endif
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         last_s = -1000;
  int         pops = 0;
  int         stall = 0;
  bit         rand_rdy = 0;
  logic [9:0] sbq[$];
  logic [7:0] pend[$];
  bit         held[int];
  int         held_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: works on whole byte sequences, not on decoder states.
  function automatic bit is_pfx(input logic [7:0] b);
    return (b == 8'hE0) || (b == 8'hE1) || (b == 8'hF0);
  endfunction

  task automatic emit(input logic [9:0] ev);
    int key;
    if (ev[7:0] == 8'hE1) begin sbq.push_back(ev); return; end
`ifdef KEY_REPEAT_FILTER_EN
    key = {ev[9], ev[6:0]};
    if (ev[8]) begin
      if (held.exists(key)) begin
        held.delete(key);
        if (held_cnt > 0) held_cnt--;
      end
    end else begin
      if (held.exists(key)) return;
      held[key] = 1;
      if (held_cnt < 15) held_cnt++;
    end
`else
    key = 0;
`endif
    sbq.push_back(ev);
  endtask

  task automatic model_byte(input logic [7:0] b, input int idle);
    bit ext, rel;
    if (idle >= TMO) pend.delete();
    if (pend.size() == 0) begin
      if (is_pfx(b)) pend.push_back(b);
      else if (!(b inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF})) emit({2'b00, b});
    end else if (pend[0] == 8'hE1) begin
      pend.push_back(b);
      if (pend.size() == 8) begin
        emit({2'b00, 8'hE1});
        pend.delete();
      end
    end else begin
      ext = (pend[0] == 8'hE0);
      rel = (pend[pend.size()-1] == 8'hF0);
      if (b == 8'hF0 && ext && pend.size() == 1) pend.push_back(b);
      else begin
        if (!is_pfx(b) && !(ext && b == 8'h12)) emit({ext, rel, b});
        pend.delete();
      end
    end
  endtask

  task automatic model_reset();
    pend.delete();
    held.delete();
    held_cnt = 0;
    sbq.delete();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_rdy) begin
      evt_ready = (stall >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
      stall = evt_ready ? 0 : stall + 1;
    end
  endtask

  task automatic put(input logic [7:0] b);
    int idle;
    idle   = cyc - last_s - 1;
    last_s = cyc;
    received_data    = b;
    received_data_en = 1'b1;
    model_byte(b, idle);
  endtask

  task automatic strobe(input logic [7:0] b);
    put(b);
    step();
    received_data_en = 1'b0;
  endtask

  task automatic idle_n(input int n);
    repeat (n) step();
  endtask

  task automatic drain();
    int n = 0;
    rand_rdy  = 0;
    evt_ready = 1'b1;
    while ((sbq.size() != 0 || evt_valid) && n < 200) begin
      step();
      n++;
    end
    idle_n(4);
    chk("drain_queue_empty", sbq.size(), 0);
    chk("drain_valid_low", evt_valid, 0);
`ifdef KEY_REPEAT_FILTER_EN
    chk("held_count", held_count, held_cnt);
`endif
  endtask

  // Monitor: pops the scoreboard on every accepted event, checks head stability under stall.
  logic [9:0] prev_head;
  bit         prev_stall = 0;
  always @(negedge clk) begin
    if (!resetn) prev_stall = 0;
    else begin
      if (prev_stall) chk("stall_hold", {evt_valid, evt_extended, evt_released, evt_code}, {1'b1, prev_head});
      if (evt_valid && evt_ready) begin
        pops++;
        if (sbq.size() == 0) chk("unexpected_event", {evt_extended, evt_released, evt_code}, 32'hFFFF_FFFF);
        else chk("event", {evt_extended, evt_released, evt_code}, sbq.pop_front());
      end
      prev_stall = evt_valid && !evt_ready;
      prev_head  = {evt_extended, evt_released, evt_code};
    end
  end

  logic [7:0] dir_bytes [22] = '{8'h1C, 8'hF0, 8'h1C, 8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75,
                                 8'hE0, 8'h12, 8'hE0, 8'h7C,
                                 8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77,
                                 8'hFA, 8'hAA};
  logic [7:0] pool [16] = '{8'hE0, 8'hF0, 8'hE1, 8'h1C, 8'h1C, 8'h12, 8'h75, 8'h7C,
                            8'h14, 8'h77, 8'h83, 8'h03, 8'hAA, 8'hFA, 8'hF0, 8'hE0};

  initial begin
    int p0;
    int r;
    resetn = 1'b0; received_data = '0; received_data_en = 1'b0; evt_ready = 1'b0;
    idle_n(3);
    chk("reset_valid", evt_valid, 0);
    chk("reset_code", evt_code, 0);
    chk("reset_ext", evt_extended, 0);
    chk("reset_rel", evt_released, 0);
    chk("reset_ovf", evt_overflow, 0);
    resetn = 1'b1;
    step();

    // Latency: strobe at edge S, push at S+1, valid visible after S+1.
    strobe(8'h1C);
    chk("latency_valid_after_1", evt_valid, 0);
    step();
    chk("latency_valid_after_2", evt_valid, 1);
    drain();

    evt_ready = 1'b1;
    p0 = pops;
    foreach (dir_bytes[i]) begin
      strobe(dir_bytes[i]);
      idle_n(1);
    end
    drain();
    chk("spec_sequence_event_count", pops - p0, 6);

    // Timeout boundary: TMO idle cycles abandon the prefix, TMO-1 do not.
    strobe(8'hE0); idle_n(TMO); strobe(8'h1C);
    idle_n(1);
    strobe(8'hE0); idle_n(TMO - 1); strobe(8'h75);
    drain();

    // Full FIFO with simultaneous pop and push: no overflow.
    evt_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin strobe(8'h30 + 8'(i)); idle_n(1); end
    idle_n(3);
    put(8'h38);
    step();
    received_data_en = 1'b0;
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
    idle_n(2);
    chk("full_push_pop_no_ovf", evt_overflow, 0);
    drain();

    // Overflow: ninth event dropped, first eight kept in order.
    evt_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin strobe(8'h40 + 8'(i)); idle_n(1); end
    idle_n(3);
    void'(sbq.pop_back());
    chk("overflow_set", evt_overflow, 1);
    chk("overflow_head_valid", evt_valid, 1);
    drain();
    chk("overflow_sticky", evt_overflow, 1);

    // Reset mid-sequence discards the pending break prefix and clears flags.
    strobe(8'hF0);
    idle_n(1);
    resetn = 1'b0;
    step();
    model_reset();
    chk("midreset_valid", evt_valid, 0);
    chk("midreset_code", evt_code, 0);
    chk("midreset_rel", evt_released, 0);
    chk("midreset_ovf", evt_overflow, 0);
    resetn = 1'b1;
    step();
    strobe(8'h1C);
    drain();

`ifdef KEY_REPEAT_FILTER_EN
    strobe(8'hF0); strobe(8'h1C);
    drain();
    p0 = pops;
    strobe(8'h1C); idle_n(1); strobe(8'h1C); idle_n(1); strobe(8'h1C); idle_n(2);
    chk("filter_held_one", held_count, 4'd1);
    strobe(8'hF0); strobe(8'h1C); idle_n(2);
    chk("filter_held_zero", held_count, 4'd0);
    drain();
    chk("filter_event_count", pops - p0, 2);
`endif

    // Randomized stream; strobes every >=4 cycles and ready high at least 1 in 4 keeps the FIFO from filling.
    rand_rdy = 1;
    for (int n = 0; n < 300; n++) begin
      strobe(pool[$urandom_range(0, 15)]);
      r = $urandom_range(0, 29);
      if (r == 0) idle_n(TMO - 2 + $urandom_range(0, 2));
      else idle_n(3 + $urandom_range(0, 3));
    end
    drain();
    chk("random_no_overflow", evt_overflow, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
